// File: rtl/clockdiv_cfg_ctrl_if.sv
// clockdiv_cfg_ctrl_if: config request handshake between the CSR layer and the reconfig sequencer
interface clockdiv_cfg_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_div;
    logic        req_auto;
    logic [15:0] req_phase0;
    logic [15:0] req_phase1;
    modport master (output req_valid, req_div, req_auto, req_phase0, req_phase1, input req_ready);
    modport slave (input req_valid, req_div, req_auto, req_phase0, req_phase1, output req_ready);
endinterface

// File: rtl/clockdiv_cfg_ctrl.sv
// clockdiv_cfg_ctrl: quiesces the clock divider, loads a new divide/phase setting and waits for it to settle
module clockdiv_cfg_ctrl #(
    parameter logic [7:0]  RESET_DIV      = 8'd1,
    parameter logic [15:0] RESET_PHASE0   = 16'h0100,
    parameter logic [15:0] RESET_PHASE1   = 16'h0100,
    parameter int          QUIESCE_CYCLES = 2,
    parameter int          TIMEOUT        = 4095
) (
    input  logic                     clk,
    input  logic                     nreset,
    clockdiv_cfg_ctrl_if.slave       req,
    output logic [7:0]               clkdiv,
    output logic [15:0]              clkphase0,
    output logic [15:0]              clkphase1,
    output logic                     clkchange,
    output logic                     clken,
    input  logic                     clkstable,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code
);
    typedef enum logic [2:0] {IDLE, CHECK, QUIESCE, LOAD, WAIT} state_t;
    state_t      state;
    logic [7:0]  s_div;
    logic        s_auto;
    logic [15:0] s_ph0;
    logic [15:0] s_ph1;
    logic [7:0]  qcnt;
    logic [11:0] timer;
    logic [8:0]  n;
    logic [7:0]  half;
    logic [7:0]  qtr;
    logic        bad;
    assign req.req_ready = state == IDLE;
    assign busy = state != IDLE;
    // auto phases: rise at 0 / fall at half for phase0, quarter-shifted for phase1; explicit bytes must not exceed div
    always_comb begin
        n = {1'b0, s_div} + 9'd1;
        half = 8'(n >> 1);
        qtr = 8'(n >> 2);
        bad = s_ph0[7:0] > s_div || s_ph0[15:8] > s_div || s_ph1[7:0] > s_div || s_ph1[15:8] > s_div;
    end
    // sequencer: accept, check, hold clken low, load with a change pulse, then wait for stable or timeout
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            s_div <= '0;
            s_auto <= 1'b0;
            s_ph0 <= '0;
            s_ph1 <= '0;
            qcnt <= '0;
            timer <= '0;
            clkdiv <= RESET_DIV;
            clkphase0 <= RESET_PHASE0;
            clkphase1 <= RESET_PHASE1;
            clkchange <= 1'b0;
            clken <= 1'b1;
            done <= 1'b0;
            err <= 1'b0;
            err_code <= 2'b00;
        end else begin
            clkchange <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: if (req.req_valid) begin
                    s_div <= req.req_div;
                    s_auto <= req.req_auto;
                    s_ph0 <= req.req_phase0;
                    s_ph1 <= req.req_phase1;
                    err_code <= 2'b00;
                    state <= CHECK;
                end
                CHECK: if (!s_auto && bad) begin
                    err <= 1'b1;
                    err_code <= 2'b01;
                    state <= IDLE;
                end else begin
                    if (s_auto) begin
                        s_ph0 <= {half, 8'd0};
                        s_ph1 <= {half + qtr, qtr};
                    end
                    qcnt <= '0;
                    state <= QUIESCE;
                end
                QUIESCE: begin
                    clken <= 1'b0;
                    if (qcnt == 8'(QUIESCE_CYCLES - 1)) state <= LOAD;
                    else qcnt <= qcnt + 8'd1;
                end
                LOAD: begin
                    clkdiv <= s_div;
                    clkphase0 <= s_ph0;
                    clkphase1 <= s_ph1;
                    clkchange <= 1'b1;
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    clken <= 1'b1;
                    if (timer != '0 && clkstable) begin
                        done <= 1'b1;
                        state <= IDLE;
                    end else if (timer == 12'(TIMEOUT)) begin
                        err <= 1'b1;
                        err_code <= 2'b10;
                        state <= IDLE;
                    end else timer <= timer + 12'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clockdiv_cfg_ctrl.sv
// tb_clockdiv_cfg_ctrl: directed checks of the clock divider reconfiguration sequencer
module tb_clockdiv_cfg_ctrl;
    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        clkstable = 1'b0;
    logic [7:0]  clkdiv;
    logic [15:0] clkphase0;
    logic [15:0] clkphase1;
    logic        clkchange;
    logic        clken;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    int          checks = 0;
    int          errors = 0;
    int          t_chg;
    int          t_end;
    int          n_err;
    int          n_done;
    int          n_chg;
    clockdiv_cfg_ctrl_if cfg();
    clockdiv_cfg_ctrl dut (
        .clk(clk),
        .nreset(nreset),
        .req(cfg.slave),
        .clkdiv(clkdiv),
        .clkphase0(clkphase0),
        .clkphase1(clkphase1),
        .clkchange(clkchange),
        .clken(clken),
        .clkstable(clkstable),
        .busy(busy),
        .done(done),
        .err(err),
        .err_code(err_code)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    // issues one request and follows it to done/err; clkstable drops on the load pulse and rises dly cycles later (never if dly<0)
    task automatic run_req(input logic [7:0] d, input logic a, input logic [15:0] p0, input logic [15:0] p1, input int dly,
                           output int tc, output int te, output int ne, output int nd);
        @(negedge clk);
        cfg.req_div = d;
        cfg.req_auto = a;
        cfg.req_phase0 = p0;
        cfg.req_phase1 = p1;
        cfg.req_valid = 1'b1;
        @(negedge clk);
        cfg.req_valid = 1'b0;
        tc = -1;
        te = -1;
        ne = 0;
        nd = 0;
        for (int c = 0; c < 5000 && te < 0; c++) begin
            if (c > 0) @(negedge clk);
            if (clkchange) begin
                tc = c;
                clkstable = 1'b0;
            end
            if (tc >= 0 && dly >= 0 && c == tc + dly) clkstable = 1'b1;
            ne += int'(err);
            nd += int'(done);
            if (done || err) te = c;
        end
    endtask
    initial begin
        cfg.req_valid = 1'b0;
        cfg.req_div = '0;
        cfg.req_auto = 1'b0;
        cfg.req_phase0 = '0;
        cfg.req_phase1 = '0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        check("rst_div", 32'(clkdiv), 32'd1);
        check("rst_ph0", 32'(clkphase0), 32'h0100);
        check("rst_ph1", 32'(clkphase1), 32'h0100);
        check("rst_clken", 32'(clken), 32'd1);
        check("rst_ready", 32'(cfg.req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", {29'd0, clkchange, done, err}, 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        @(negedge clk);
        cfg.req_div = 8'd3;
        cfg.req_auto = 1'b1;
        cfg.req_valid = 1'b1;
        @(negedge clk);
        check("auto_c0_busy", 32'(busy), 32'd1);
        check("auto_c0_ready", 32'(cfg.req_ready), 32'd0);
        cfg.req_div = 8'd9;
        @(negedge clk);
        check("auto_c1_clken", 32'(clken), 32'd1);
        @(negedge clk);
        check("auto_c2_clken", 32'(clken), 32'd0);
        @(negedge clk);
        check("auto_c3_clken", 32'(clken), 32'd0);
        check("auto_c3_chg", 32'(clkchange), 32'd0);
        check("auto_c3_div", 32'(clkdiv), 32'd1);
        @(negedge clk);
        check("auto_c4_chg", 32'(clkchange), 32'd1);
        check("auto_c4_clken", 32'(clken), 32'd0);
        check("auto_c4_div", 32'(clkdiv), 32'd3);
        check("auto_c4_ph0", 32'(clkphase0), 32'h0200);
        check("auto_c4_ph1", 32'(clkphase1), 32'h0301);
        clkstable = 1'b1;
        cfg.req_valid = 1'b0;
        @(negedge clk);
        check("auto_c5_clken", 32'(clken), 32'd1);
        check("auto_c5_chg", 32'(clkchange), 32'd0);
        check("auto_c5_done", 32'(done), 32'd0);
        @(negedge clk);
        check("auto_c6_done", 32'(done), 32'd1);
        check("auto_c6_err", 32'(err), 32'd0);
        check("auto_c6_ready", 32'(cfg.req_ready), 32'd1);
        @(negedge clk);
        check("auto_c7_done", 32'(done), 32'd0);
        check("busy_req_ignored", 32'(clkdiv), 32'd3);
        check("auto_c7_busy", 32'(busy), 32'd0);
        run_req(8'd4, 1'b0, 16'h0402, 16'h0301, 2, t_chg, t_end, n_err, n_done);
        check("expl_tchg", 32'(t_chg), 32'd4);
        check("expl_tend", 32'(t_end), 32'd7);
        check("expl_ndone", 32'(n_done), 32'd1);
        check("expl_nerr", 32'(n_err), 32'd0);
        check("expl_div", 32'(clkdiv), 32'd4);
        check("expl_ph0", 32'(clkphase0), 32'h0402);
        check("expl_ph1", 32'(clkphase1), 32'h0301);
        run_req(8'd4, 1'b0, 16'h0605, 16'h0000, 2, t_chg, t_end, n_err, n_done);
        check("range_tchg", 32'(t_chg), 32'hffffffff);
        check("range_tend", 32'(t_end), 32'd1);
        check("range_nerr", 32'(n_err), 32'd1);
        check("range_ndone", 32'(n_done), 32'd0);
        check("range_code", 32'(err_code), 32'd1);
        check("range_div", 32'(clkdiv), 32'd4);
        check("range_ph0", 32'(clkphase0), 32'h0402);
        run_req(8'd0, 1'b1, 16'hffff, 16'hffff, 1, t_chg, t_end, n_err, n_done);
        check("byp_tend", 32'(t_end), 32'd6);
        check("byp_code", 32'(err_code), 32'd0);
        check("byp_div", 32'(clkdiv), 32'd0);
        check("byp_ph", {clkphase0, clkphase1}, 32'h0);
        run_req(8'd200, 1'b1, 16'h0, 16'h0, 3, t_chg, t_end, n_err, n_done);
        check("d200_tend", 32'(t_end), 32'd8);
        check("d200_ph0", 32'(clkphase0), 32'h6400);
        check("d200_ph1", 32'(clkphase1), 32'h9632);
        run_req(8'd2, 1'b1, 16'h0, 16'h0, 2304, t_chg, t_end, n_err, n_done);
        check("wrap_tchg", 32'(t_chg), 32'd4);
        check("wrap_tend", 32'(t_end), 32'd2309);
        check("wrap_ndone", 32'(n_done), 32'd1);
        check("wrap_nerr", 32'(n_err), 32'd0);
        check("wrap_div", 32'(clkdiv), 32'd2);
        run_req(8'd7, 1'b1, 16'h0, 16'h0, -1, t_chg, t_end, n_err, n_done);
        check("tmo_tend", 32'(t_end), 32'd4100);
        check("tmo_nerr", 32'(n_err), 32'd1);
        check("tmo_ndone", 32'(n_done), 32'd0);
        check("tmo_code", 32'(err_code), 32'd2);
        check("tmo_clken", 32'(clken), 32'd1);
        check("tmo_div", 32'(clkdiv), 32'd7);
        check("tmo_ph0", 32'(clkphase0), 32'h0400);
        check("tmo_ph1", 32'(clkphase1), 32'h0602);
        @(negedge clk);
        check("tmo_ready", 32'(cfg.req_ready), 32'd1);
        check("tmo_err_clr", 32'(err), 32'd0);
        cfg.req_div = 8'd9;
        cfg.req_auto = 1'b1;
        cfg.req_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("nrst_quiesce", 32'(clken), 32'd0);
        #2 nreset = 1'b0;
        #1;
        check("nrst_div", 32'(clkdiv), 32'd1);
        check("nrst_ph", {clkphase0, clkphase1}, 32'h01000100);
        check("nrst_clken", 32'(clken), 32'd1);
        check("nrst_busy", 32'(busy), 32'd0);
        check("nrst_ready", 32'(cfg.req_ready), 32'd1);
        check("nrst_code", 32'(err_code), 32'd0);
        cfg.req_valid = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        n_chg = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_chg += int'(clkchange) + int'(busy);
        end
        check("nrst_dropped", 32'(n_chg), 32'd0);
        check("nrst_div_kept", 32'(clkdiv), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
